// File: rtl/rast_tri_pkg.sv
// Shared types for the rasterizer triangle front-end.
// Word widths, triangle/colour bundles, FIFO entry and issue FSM state.
package rast_tri_pkg;

  localparam int SIGFIG     = 24;
  localparam int RADIX      = 10;
  localparam int VERTS      = 3;
  localparam int AXIS       = 3;
  localparam int COLORS     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int TRI_ID_W   = 16;

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

  typedef struct packed {
    tri_t   tv;
    color_t col;
  } tri_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } out_state_e;

endpackage

// File: rtl/tri_issue_queue_fifo.sv
// Count-based FIFO of triangle entries with registered full/empty.
// Ports: clk, rst (sync, active-low), push_i/wdata_i, pop_i/rdata_o (head), full_o, empty_o.
module tri_fifo
  import rast_tri_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH,
  parameter type T     = tri_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // A full FIFO rejects a push even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_C);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset; pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/tri_issue_queue.sv
// Triangle issue queue: buffers loaded triangles, issues one per cycle into R10 with halt hold.
// Ports: loader side (tri_in_S, color_in_U, push_in, full/empty/overflow), R10 side (data, valid, id, issued_cnt).
module tri_issue_queue
  import rast_tri_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int ID_W  = TRI_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  tri_t            tri_in_S,
  input  color_t          color_in_U,
  input  logic            push_in,
  output logic            full_out,
  output logic            empty_out,
  output logic            overflow_err,
  input  logic            halt_RnnH,
  output tri_t            tri_R10S,
  output color_t          color_R10U,
  output logic            validTri_R10H,
  output logic [ID_W-1:0] tri_id_R10U,
  output logic [31:0]     issued_cnt
);

  out_state_e      state_q, state_d;
  tri_entry_t      wr_ent, head;
  tri_entry_t      out_q;
  logic [ID_W-1:0] id_q, seq_q;
  logic [31:0]     cnt_q;
  logic            ovf_q;
  logic            fifo_full, fifo_empty;
  logic            pop;

  assign wr_ent.tv  = tri_in_S;
  assign wr_ent.col = color_in_U;

  tri_fifo #(
    .DEPTH(DEPTH),
    .T    (tri_entry_t)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_in),
    .wdata_i(wr_ent),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = pop ? SEND : IDLE;
      SEND, HOLD: begin
        if (halt_RnnH)  state_d = HOLD;
        else if (pop)   state_d = SEND;
        else            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Halt only matters while a triangle is being presented.
  always_comb begin
    validTri_R10H = (state_q != IDLE);
    pop = !fifo_empty && (!validTri_R10H || !halt_RnnH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q <= '0;
      id_q  <= '0;
      seq_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (pop) begin
        out_q <= head;
        id_q  <= seq_q;
        seq_q <= seq_q + 1'b1;
        cnt_q <= cnt_q + 1'b1;
      end
      if (push_in && fifo_full) ovf_q <= 1'b1;
    end
  end

  assign tri_R10S     = out_q.tv;
  assign color_R10U   = out_q.col;
  assign tri_id_R10U  = id_q;
  assign issued_cnt   = cnt_q;
  assign overflow_err = ovf_q;
  assign full_out     = fifo_full;
  assign empty_out    = fifo_empty;

endmodule
